// File: rtl/qpsk_diff_decoder_pkg.sv
// Shared definitions for the QPSK differential decoder: phase indices,
// delta-to-dibit map constants, FSM state encoding and slicing helpers.
// Optional build macro used by the top: QPSK_DIFF_ERASURE_CNT_EN.
package qpsk_diff_decoder_pkg;

    localparam int unsigned PHASE_W = 2;
    localparam int unsigned SYM_W   = 2;
    localparam int unsigned ERAS_W  = 16;

    // Phase indices, counter-clockwise starting at (+1,+1)
    localparam logic [PHASE_W-1:0] PH_0 = 2'd0;
    localparam logic [PHASE_W-1:0] PH_1 = 2'd1;
    localparam logic [PHASE_W-1:0] PH_2 = 2'd2;
    localparam logic [PHASE_W-1:0] PH_3 = 2'd3;

    // Dibit carried by each phase step {I bit, Q bit}
    localparam logic [1:0] DIBIT_D0 = 2'b00;
    localparam logic [1:0] DIBIT_D1 = 2'b01;
    localparam logic [1:0] DIBIT_D2 = 2'b11;
    localparam logic [1:0] DIBIT_D3 = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } state_t;

    typedef struct packed {
        logic i_bit;
        logic q_bit;
    } dibit_t;

    // Quadrant sign bits {i_bit,q_bit} (1 = negative) to phase index
    function automatic logic [PHASE_W-1:0] slice_phase(input logic i_bit, input logic q_bit);
        logic [PHASE_W-1:0] ph;
        case ({i_bit, q_bit})
            2'b00:   ph = PH_0;
            2'b10:   ph = PH_1;
            2'b11:   ph = PH_2;
            default: ph = PH_3;
        endcase
        return ph;
    endfunction

    // Phase step to transmitted dibit
    function automatic dibit_t delta_to_dibit(input logic [PHASE_W-1:0] delta);
        logic [1:0] d;
        case (delta)
            PH_0:    d = DIBIT_D0;
            PH_1:    d = DIBIT_D1;
            PH_2:    d = DIBIT_D2;
            default: d = DIBIT_D3;
        endcase
        return dibit_t'(d);
    endfunction

endpackage

// File: rtl/qpsk_phase_delta.sv
// Combinational phase slicer and differential demapper.
// Ports: sym_i/sym_q signed hard decisions, prev_phase previous phase index;
//        cur_phase phase index of this symbol, dibit recovered {I,Q} bits.
module qpsk_phase_delta
    import qpsk_diff_decoder_pkg::*;
(
    input  logic [SYM_W-1:0]   sym_i,
    input  logic [SYM_W-1:0]   sym_q,
    input  logic [PHASE_W-1:0] prev_phase,
    output logic [PHASE_W-1:0] cur_phase,
    output dibit_t             dibit
);

    logic [PHASE_W-1:0] delta_c;

    // Sign bit decides the quadrant; a zero value slices as positive
    always_comb begin
        cur_phase = slice_phase(sym_i[SYM_W-1], sym_q[SYM_W-1]);
        delta_c   = PHASE_W'(cur_phase - prev_phase);
        dibit     = delta_to_dibit(delta_c);
    end

endmodule

// File: rtl/qpsk_diff_decoder.sv
// QPSK differential decoder: recovers a dibit from the phase step between
// consecutive hard-decision symbols and serialises it I bit first.
// Ports: clk_8megahz, rst_n (async, active-low); sym_i/sym_q/sym_valid/
//        sym_ready symbol stream in; sync_clr reloads the previous phase;
//        bit_data/bit_valid/bit_ready serial bit stream out.
// Build macro QPSK_DIFF_ERASURE_CNT_EN adds erasure_cnt, a saturating count
// of accepted symbols with a zero-valued I or Q component.
module qpsk_diff_decoder
    import qpsk_diff_decoder_pkg::*;
#(
    parameter logic [PHASE_W-1:0] PHASE_INIT = PH_0
) (
    input  logic               clk_8megahz,
    input  logic               rst_n,
    input  logic [SYM_W-1:0]   sym_i,
    input  logic [SYM_W-1:0]   sym_q,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic               sync_clr,
    output logic               bit_data,
    output logic               bit_valid,
    input  logic               bit_ready
`ifdef QPSK_DIFF_ERASURE_CNT_EN
    ,
    output logic [ERAS_W-1:0]  erasure_cnt
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-1:0] prev_phase;
    logic [PHASE_W-1:0] prev_sel_c;
    logic [PHASE_W-1:0] cur_phase_c;
    dibit_t             dibit_q;
    dibit_t             dibit_c;
    dibit_t             dibit_nxt;
    logic               bit_data_nxt;
    logic               bit_valid_nxt;
    logic               alive;
    logic               accept_c;

    // sync_clr coinciding with an accept differences against PHASE_INIT
    assign prev_sel_c = sync_clr ? PHASE_INIT : prev_phase;

    qpsk_phase_delta u_phase_delta (
        .sym_i      (sym_i),
        .sym_q      (sym_q),
        .prev_phase (prev_sel_c),
        .cur_phase  (cur_phase_c),
        .dibit      (dibit_c)
    );

    // Ready is held low through reset and the cycle of its release
    always_comb begin
        sym_ready = alive && ((state == IDLE) || ((state == SEND_Q) && bit_ready));
    end

    assign accept_c = sym_valid && sym_ready;

    // State register
    always_ff @(posedge clk_8megahz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, next dibit and next registered bit outputs
    always_comb begin
        state_nxt     = state;
        dibit_nxt     = dibit_q;
        bit_valid_nxt = 1'b0;
        bit_data_nxt  = 1'b0;

        if (accept_c) begin
            dibit_nxt = dibit_c;
        end

        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = SEND_I;
                end
            end
            SEND_I: begin
                if (bit_ready) begin
                    state_nxt = SEND_Q;
                end
            end
            SEND_Q: begin
                if (bit_ready) begin
                    state_nxt = accept_c ? SEND_I : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state presents
        if (state_nxt == SEND_I) begin
            bit_valid_nxt = 1'b1;
            bit_data_nxt  = dibit_nxt.i_bit;
        end else if (state_nxt == SEND_Q) begin
            bit_valid_nxt = 1'b1;
            bit_data_nxt  = dibit_nxt.q_bit;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_8megahz or negedge rst_n) begin
        if (!rst_n) begin
            alive      <= 1'b0;
            prev_phase <= PHASE_INIT;
            dibit_q    <= '0;
            bit_data   <= 1'b0;
            bit_valid  <= 1'b0;
        end else begin
            alive     <= 1'b1;
            dibit_q   <= dibit_nxt;
            bit_data  <= bit_data_nxt;
            bit_valid <= bit_valid_nxt;
            if (accept_c) begin
                prev_phase <= cur_phase_c;
            end else if (sync_clr) begin
                prev_phase <= PHASE_INIT;
            end
        end
    end

`ifdef QPSK_DIFF_ERASURE_CNT_EN
    logic is_erasure_c;

    assign is_erasure_c = (sym_i == '0) || (sym_q == '0);

    // Saturating erasure counter, cleared by sync_clr
    always_ff @(posedge clk_8megahz or negedge rst_n) begin
        if (!rst_n) begin
            erasure_cnt <= '0;
        end else if (sync_clr) begin
            erasure_cnt <= '0;
        end else if (accept_c && is_erasure_c && (erasure_cnt != '1)) begin
            erasure_cnt <= erasure_cnt + ERAS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_diff_decoder.sv
// Self-checking bench for qpsk_diff_decoder: directed vector table, stall,
// back-to-back, mid-serialisation reset and randomized traffic against a
// queue-based reference model.
module tb_qpsk_diff_decoder;

    logic       clk_8megahz = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sym_i = 2'b00;
    logic [1:0] sym_q = 2'b00;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic       sync_clr = 1'b0;
    logic       bit_data;
    logic       bit_valid;
    logic       bit_ready = 1'b0;
`ifdef QPSK_DIFF_ERASURE_CNT_EN
    logic [15:0] erasure_cnt;
`endif

    qpsk_diff_decoder dut (
        .clk_8megahz (clk_8megahz),
        .rst_n       (rst_n),
        .sym_i       (sym_i),
        .sym_q       (sym_q),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sync_clr    (sync_clr),
        .bit_data    (bit_data),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready)
`ifdef QPSK_DIFF_ERASURE_CNT_EN
        ,
        .erasure_cnt (erasure_cnt)
`endif
    );

    always #5 clk_8megahz = ~clk_8megahz;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   m_prev = 0;
    int   m_er   = 0;
    int   exp_q[$];
    logic got_q[$];
    bit   tb_alive = 1'b0;

    typedef struct {
        logic [1:0] si;
        logic [1:0] sq;
        logic       clr;
        logic [1:0] exp_dibit;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Constellation quadrant counted counter-clockwise from (+,+)
    function automatic int phase_of(input logic [1:0] i, input logic [1:0] q);
        bit ip = (i[1] == 1'b0);
        bit qp = (q[1] == 1'b0);
        if (ip && qp)   return 0;
        if (!ip && qp)  return 1;
        if (!ip && !qp) return 2;
        return 3;
    endfunction

    // One clock: drive inputs, check outputs vs model, advance model and clock
    task automatic cycle(input logic sv, input logic [1:0] si, input logic [1:0] sq,
                         input logic br, input logic clr, output bit acc, output bit bv);
        int  cur;
        int  pp;
        int  d;
        int  g;
        bit  mready;
        sym_valid = sv;
        sym_i     = si;
        sym_q     = sq;
        bit_ready = br;
        sync_clr  = clr;
        #1;
        acc    = 1'b0;
        bv     = bit_valid;
        mready = tb_alive && ((exp_q.size() == 0) || ((exp_q.size() == 1) && br));
        if (tb_alive) begin
            chk("bit_valid", 32'(bit_valid), 32'(exp_q.size() != 0));
            chk("sym_ready", 32'(sym_ready), 32'(mready));
            if (exp_q.size() != 0) chk("bit_data", 32'(bit_data), 32'(exp_q[0]));
`ifdef QPSK_DIFF_ERASURE_CNT_EN
            chk("erasure_cnt", 32'(erasure_cnt), 32'(m_er));
`endif
        end
        if (bit_valid && br && exp_q.size() != 0) begin
            got_q.push_back(bit_data);
            void'(exp_q.pop_front());
        end
        if (sv && mready) begin
            cur = phase_of(si, sq);
            pp  = clr ? 0 : m_prev;
            d   = (cur - pp + 4) % 4;
            g   = d ^ (d >> 1);
            exp_q.push_back((g >> 1) & 1);
            exp_q.push_back(g & 1);
            m_prev = cur;
            acc = 1'b1;
        end else if (clr) begin
            m_prev = 0;
        end
        if (clr) m_er = 0;
        else if (acc && (si == 2'b00 || sq == 2'b00) && m_er < 65535) m_er++;
        @(posedge clk_8megahz);
        #1;
        tb_alive = 1'b1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        bit_ready = 1'b0;
        sync_clr  = 1'b0;
        #1;
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_bit_data", 32'(bit_data), 32'd0);
        chk("rst_sym_ready", 32'(sym_ready), 32'd0);
`ifdef QPSK_DIFF_ERASURE_CNT_EN
        chk("rst_erasure_cnt", 32'(erasure_cnt), 32'd0);
`endif
        exp_q.delete();
        got_q.delete();
        m_prev   = 0;
        m_er     = 0;
        tb_alive = 1'b0;
        @(posedge clk_8megahz);
        #1;
        rst_n = 1'b1;
        @(posedge clk_8megahz);
        #1;
        tb_alive = 1'b1;
        chk("post_rst_sym_ready", 32'(sym_ready), 32'd1);
    endtask

    task automatic drain();
        bit a;
        bit v;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, a, v);
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input logic [1:0] si, input logic [1:0] sq, input logic clr);
        bit a;
        bit v;
        a = 1'b0;
        for (int k = 0; k < 10 && !a; k++) cycle(1'b1, si, sq, 1'b1, clr, a, v);
        if (!a) chk("send_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] got_pair();
        logic [1:0] g;
        if (got_q.size() != 2) return 32'hdead;
        g = {got_q[0], got_q[1]};
        return 32'(g);
    endfunction

    vec_t vecs[10];

    initial begin
        bit a;
        bit v;
        int n_acc;
        int n_bv;

        vecs[0] = '{2'b01, 2'b01, 1'b0, 2'b00};
        vecs[1] = '{2'b11, 2'b01, 1'b0, 2'b01};
        vecs[2] = '{2'b01, 2'b11, 1'b0, 2'b11};
        vecs[3] = '{2'b01, 2'b01, 1'b0, 2'b01};
        vecs[4] = '{2'b11, 2'b01, 1'b0, 2'b01};
        vecs[5] = '{2'b11, 2'b11, 1'b1, 2'b11};
        vecs[6] = '{2'b01, 2'b01, 1'b0, 2'b11};
        vecs[7] = '{2'b00, 2'b00, 1'b0, 2'b00};
        vecs[8] = '{2'b11, 2'b00, 1'b0, 2'b01};
        vecs[9] = '{2'b10, 2'b10, 1'b0, 2'b01};

        // Directed vector table, including the sync_clr-on-accept case
        do_reset();
        for (int i = 0; i < 10; i++) begin
            got_q.delete();
            send(vecs[i].si, vecs[i].sq, vecs[i].clr);
            drain();
            chk($sformatf("vec%0d_dibit", i), got_pair(), 32'(vecs[i].exp_dibit));
        end

        // Downstream stall during SEND_I of dibit 01
        do_reset();
        cycle(1'b1, 2'b11, 2'b01, 1'b0, 1'b0, a, v);
        chk("stall_accept", 32'(a), 32'd1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, a, v);
        chk("stall_hold_valid", 32'(bit_valid), 32'd1);
        chk("stall_hold_data", 32'(bit_data), 32'd0);
        chk("stall_sym_ready", 32'(sym_ready), 32'd0);
        got_q.delete();
        drain();
        chk("stall_bits", got_pair(), 32'd1);

        // Continuous sym_valid: back-to-back symbols, no idle gap
        do_reset();
        n_acc = 0;
        n_bv  = 0;
        for (int k = 0; k < 11; k++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1, 1'b0, a, v);
            n_acc += int'(a);
            n_bv  += int'(v);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, a, v);
            n_bv += int'(v);
        end
        chk("b2b_accepts", 32'(n_acc), 32'd6);
        chk("b2b_valid_cycles", 32'(n_bv), 32'd12);

        // Reset while in SEND_Q discards the pending bit
        do_reset();
        cycle(1'b1, 2'b11, 2'b11, 1'b1, 1'b0, a, v);
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, a, v);
        chk("sendq_valid", 32'(bit_valid), 32'd1);
        do_reset();
        send(2'b01, 2'b01, 1'b0);
        drain();
        chk("post_midrst_bits", got_pair(), 32'd0);

`ifdef QPSK_DIFF_ERASURE_CNT_EN
        // Erasure counting and clear
        do_reset();
        for (int k = 0; k < 3; k++) send(2'b01, 2'b00, 1'b0);
        drain();
        chk("erasure_3", 32'(erasure_cnt), 32'd3);
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, a, v);
        chk("erasure_clr", 32'(erasure_cnt), 32'd0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), a, v);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
